// File: rtl/wallace_ks_8bit_mac.sv
// wallace_ks_8bit_mac: unsigned 8x8 multiply-accumulate, acc <= acc + a*b + cin.
// The 64 partial products and the accumulator are compressed in a Wallace tree down to two
// rows, and a 16-bit Kogge-Stone prefix adder (cin at bit 0) finishes the sum.
// Optional feature macro: MAC_SATURATE_EN (saturate to 16'hFFFF instead of wrapping).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   a    - 8-bit unsigned multiplicand
//   b    - 8-bit unsigned multiplier
//   cin  - carry-in at LSB weight
//   out  - 16-bit registered accumulator
//   cout - registered carry (bit 16) of the most recent accumulation
module wallace_ks_8bit_mac (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        cin,
    output logic [15:0] out,
    output logic        cout
);

    logic [15:0] r_acc;
    logic        r_cout;

    logic [15:0] w_row0;
    logic [15:0] w_row1;
    logic        w_top;     // tree bits that landed at weight 2^16
    logic [15:0] w_sum;
    logic        w_c16;
    logic        w_carry;

    // Column-wise Wallace compression. Each column holds up to 16 bits; columns taller than
    // two are reduced with full adders on groups of three and a half adder on a leftover pair.
    always_comb begin : p_tree
        logic [15:0] col  [18];
        logic [15:0] ncol [18];
        int          h    [18];
        int          nh   [18];
        int          n;
        int          base;
        logic        x0, x1, x2;

        for (int c = 0; c < 18; c++) begin
            col[c]  = '0;
            ncol[c] = '0;
            h[c]    = 0;
            nh[c]   = 0;
        end
        n    = 0;
        base = 0;
        x0   = 1'b0;
        x1   = 1'b0;
        x2   = 1'b0;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col[i+j][h[i+j]] = a[i] & b[j];
                h[i+j]           = h[i+j] + 1;
            end
        end
        // Accumulator folded in as an extra carry-save operand.
        for (int c = 0; c < 16; c++) begin
            col[c][h[c]] = r_acc[c];
            h[c]         = h[c] + 1;
        end

        // Enough stages for the worst carry ripple across all columns.
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 18; c++) begin
                ncol[c] = '0;
                nh[c]   = 0;
            end
            for (int c = 0; c < 17; c++) begin
                n = h[c];
                if (n <= 2) begin
                    for (int k = 0; k < 2; k++) begin
                        if (k < n) begin
                            ncol[c][nh[c]] = col[c][k];
                            nh[c]          = nh[c] + 1;
                        end
                    end
                end else begin
                    for (int g = 0; g < 5; g++) begin
                        if (3 * g + 3 <= n) begin
                            x0 = col[c][3*g];
                            x1 = col[c][3*g+1];
                            x2 = col[c][3*g+2];
                            ncol[c][nh[c]]     = x0 ^ x1 ^ x2;
                            nh[c]              = nh[c] + 1;
                            ncol[c+1][nh[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
                            nh[c+1]            = nh[c+1] + 1;
                        end
                    end
                    base = 3 * (n / 3);
                    if (n - base == 2) begin
                        x0 = col[c][base];
                        x1 = col[c][base+1];
                        ncol[c][nh[c]]     = x0 ^ x1;
                        nh[c]              = nh[c] + 1;
                        ncol[c+1][nh[c+1]] = x0 & x1;
                        nh[c+1]            = nh[c+1] + 1;
                    end else if (n - base == 1) begin
                        ncol[c][nh[c]] = col[c][base];
                        nh[c]          = nh[c] + 1;
                    end
                end
            end
            for (int c = 0; c < 18; c++) begin
                col[c] = ncol[c];
                h[c]   = nh[c];
            end
        end

        w_row0 = '0;
        w_row1 = '0;
        for (int c = 0; c < 16; c++) begin
            w_row0[c] = (h[c] > 0) ? col[c][0] : 1'b0;
            w_row1[c] = (h[c] > 1) ? col[c][1] : 1'b0;
        end
        // The exact sum fits in 17 bits, so at most one bit survives at weight 2^16.
        w_top = (h[16] > 0) ? (col[16][0] | col[16][1]) : 1'b0;
    end

    // Kogge-Stone: cin is absorbed into the bit-0 generate, then four prefix levels.
    always_comb begin : p_ks
        logic [15:0] p0;
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] ng;
        logic [15:0] np;
        int          d;

        p0    = w_row0 ^ w_row1;
        g     = w_row0 & w_row1;
        g[0]  = g[0] | (p0[0] & cin);
        p     = p0;
        ng    = '0;
        np    = '0;
        d     = 1;
        for (int l = 0; l < 4; l++) begin
            d  = 1 << l;
            ng = g;
            np = p;
            for (int i = 0; i < 16; i++) begin
                if (i >= d) begin
                    ng[i] = g[i] | (p[i] & g[i-d]);
                    np[i] = p[i] & p[i-d];
                end
            end
            g = ng;
            p = np;
        end
        w_sum = p0 ^ {g[14:0], cin};
        w_c16 = g[15];
    end

    assign w_carry = w_c16 | w_top;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= 16'h0000;
            r_cout <= 1'b0;
        end else begin
`ifdef MAC_SATURATE_EN
            if (w_carry) begin
                r_acc  <= 16'hFFFF;
                r_cout <= 1'b1;
            end else begin
                r_acc  <= w_sum;
                r_cout <= 1'b0;
            end
`else
            r_acc  <= w_sum;
            r_cout <= w_carry;
`endif
        end
    end

    assign out  = r_acc;
    assign cout = r_cout;

endmodule

// File: tb/tb_wallace_ks_8bit_mac.sv
module tb_wallace_ks_8bit_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [15:0] out;
    logic        cout;

    int unsigned m_acc  = 0;
    int unsigned m_cout = 0;
    int          vectors = 0;
    int          errors  = 0;

    wallace_ks_8bit_mac dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .out  (out),
        .cout (cout)
    );

    always #5 clk = ~clk;

    // Reference: exact 17-bit arithmetic on plain integers.
    task automatic model_update(input logic r, input int unsigned ma, input int unsigned mb,
                                input int unsigned mc);
        int unsigned s;
        if (r) begin
            m_acc  = 0;
            m_cout = 0;
        end else begin
            s = m_acc + ma * mb + mc;
`ifdef MAC_SATURATE_EN
            if (s >= 65536) begin
                m_acc  = 65535;
                m_cout = 1;
            end else begin
                m_acc  = s;
                m_cout = 0;
            end
`else
            m_acc  = s % 65536;
            m_cout = s / 65536;
`endif
        end
    endtask

    task automatic compare(input string name);
        vectors++;
        if (out !== m_acc[15:0] || cout !== m_cout[0]) begin
            errors++;
            $display("FAIL %s: out=%0d cout=%b, required out=%0d cout=%0d (a=%0d b=%0d cin=%b rst=%b)",
                     name, out, cout, m_acc, m_cout, a, b, cin, rst);
        end
    endtask

    // Hand-computed expectation that pins the model and the DUT together.
    task automatic expect_lit(input string name, input int unsigned eo, input int unsigned ec);
        vectors++;
        if (out !== eo[15:0] || cout !== ec[0] || m_acc != eo || m_cout != ec) begin
            errors++;
            $display("FAIL %s: out=%0d cout=%b model=%0d/%0d, required out=%0d cout=%0d",
                     name, out, cout, m_acc, m_cout, eo, ec);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] sa, input logic [7:0] sb,
                        input logic sc, input string name);
        rst = r;
        a   = sa;
        b   = sb;
        cin = sc;
        @(posedge clk);
        #1;
        model_update(r, int'(sa), int'(sb), int'(sc));
        compare(name);
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;

        step(1'b1, 8'd0, 8'd0, 1'b0, "reset");
        expect_lit("reset_lit", 0, 0);
        step(1'b0, 8'd0, 8'd0, 1'b0, "hold_zero");
        expect_lit("hold_zero_lit", 0, 0);

        step(1'b0, 8'd12, 8'd15, 1'b0, "acc1");
        expect_lit("acc1_lit", 180, 0);
        step(1'b0, 8'd8, 8'd10, 1'b0, "acc2");
        expect_lit("acc2_lit", 260, 0);
        step(1'b0, 8'd25, 8'd30, 1'b0, "acc3");
        expect_lit("acc3_lit", 1010, 0);
        step(1'b0, 8'd100, 8'd50, 1'b0, "acc4");
        expect_lit("acc4_lit", 6010, 0);

        step(1'b0, 8'd255, 8'd255, 1'b0, "wrap1");
`ifdef MAC_SATURATE_EN
        expect_lit("wrap1_lit", 65535, 1);
`else
        expect_lit("wrap1_lit", 5499, 1);
`endif
        step(1'b0, 8'd255, 8'd255, 1'b0, "wrap2");
`ifdef MAC_SATURATE_EN
        expect_lit("wrap2_lit", 65535, 1);
`else
        expect_lit("wrap2_lit", 4988, 1);
`endif

        step(1'b1, 8'd0, 8'd0, 1'b0, "reset2");
        step(1'b0, 8'd0, 8'd0, 1'b1, "cin1");
        expect_lit("cin1_lit", 1, 0);
        step(1'b0, 8'd0, 8'd0, 1'b1, "cin2");
        expect_lit("cin2_lit", 2, 0);
        step(1'b0, 8'd0, 8'd0, 1'b1, "cin3");
        expect_lit("cin3_lit", 3, 0);
        step(1'b0, 8'd1, 8'd1, 1'b1, "cin4");
        expect_lit("cin4_lit", 5, 0);

        step(1'b0, 8'd77, 8'd91, 1'b0, "pre_rst");
        step(1'b1, 8'd200, 8'd200, 1'b0, "mid_rst");
        expect_lit("mid_rst_lit", 0, 0);
        step(1'b0, 8'd3, 8'd4, 1'b0, "post_rst");
        expect_lit("post_rst_lit", 12, 0);

        // Accumulator at 65535 followed by cin=1.
        step(1'b1, 8'd0, 8'd0, 1'b0, "reset3");
        step(1'b0, 8'd255, 8'd255, 1'b0, "top1");
        step(1'b0, 8'd2, 8'd255, 1'b0, "top2");
        expect_lit("top2_lit", 65535, 0);
        step(1'b0, 8'd0, 8'd0, 1'b1, "top_cin");
`ifdef MAC_SATURATE_EN
        expect_lit("top_cin_lit", 65535, 1);
`else
        expect_lit("top_cin_lit", 0, 1);
`endif

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            logic       rr;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 99) == 0);
            if (i % 97 == 10) begin
                ra = 8'd0;
                rb = 8'd255;
            end else if (i % 97 == 20) begin
                ra = 8'd255;
                rb = 8'd1;
            end else if (i % 97 == 30) begin
                ra = 8'd255;
                rb = 8'd255;
            end
            step(rr, ra, rb, rc, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wallace_ks_8bit_mac.md
Name: wallace_ks_8bit_mac

Overview:
- Unsigned 8x8 multiply-accumulate unit. Each clock: acc <= acc + a*b + cin.
- The multiplier is a Wallace-tree partial-product reducer. The final carry-propagate addition is a 16-bit Kogge-Stone parallel-prefix adder.
- Used as the datapath MAC core in the high-performance MAC comparison designs. Same port list as the Brent-Kung variant, so the two are drop-in interchangeable.

Parameters:
- None. Widths are fixed: 8-bit operands, 16-bit accumulator, 1-bit carry-out.

Ports:
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous, active-high reset
- a    input  8  unsigned multiplicand
- b    input  8  unsigned multiplier
- cin  input  1  carry-in, added at LSB weight into the accumulation
- out  output 16 accumulator register value (registered output)
- cout output 1  registered carry-out (bit 16) of the most recent accumulation

Behaviour:
- Reset:
  - Synchronous, active-high.
  - On a rising clk edge with rst=1: out <= 16'h0000 and cout <= 0. The a, b and cin inputs are ignored on that edge.
  - Reset has priority over accumulation. Asserting rst mid-stream clears the accumulator on the next edge, with no partial update.
- Accumulate:
  - On every rising edge with rst=0: {cout, out} <= out + (a*b) + cin, computed as an exact 17-bit sum.
  - Max sum is 65535 + 65025 + 1 < 2^17, so one carry bit is always exact.
  - The accumulator wraps modulo 2^16. cout is the carry of that single addition and is not sticky: it is re-evaluated every cycle.
- Latency:
  - One cycle. Inputs sampled at edge N appear in out/cout after edge N.
  - No enable and no handshake: the unit accumulates on every non-reset cycle, including a=b=0 cycles (accumulator holds when the product is 0 and cin=0).
- Multiplier:
  - 64 AND-gate partial products.
  - Wallace reduction with full/half adders down to two 16-bit rows.
  - The accumulator value is folded into the carry-save tree as a third operand before the final adder.
  - No pipeline register inside the tree.
- Final adder:
  - 16-bit Kogge-Stone prefix adder: generate/propagate, log2(16)=4 prefix levels, cin as carry-in at bit 0.
  - Carry out of bit 15 combines with the tree's bit-16 carry to form cout.
- Outputs are driven only from registers; there are no combinational paths from inputs to outputs.
- X on the inputs while rst=1 does not affect state.

Optional Feature:
- Macro MAC_SATURATE_EN.
- Defined: if the 17-bit sum is >= 2^16, then out <= 16'hFFFF and cout <= 1. The accumulator stays at FFFF until reset, since further non-negative additions keep it saturated.
- Not defined (default): wrap-around modulo 2^16 as specified above, with cout reporting the carry.

Test Plan:
- Reset: hold rst=1 over one edge with a=0, b=0, cin=0 -> out=0, cout=0. Release rst, one edge with a=b=0 -> out stays 0.
- Sequential accumulation, cin=0, one edge each:
  - (12,15) -> out=180
  - (8,10) -> out=260
  - (25,30) -> out=1010
  - (100,50) -> out=6010
  - cout=0 throughout.
- Overflow wrap: from out=6010, apply (255,255) -> out=5499, cout=1. Hold (255,255) for another edge -> out=4988, cout=1. With MAC_SATURATE_EN defined: out=65535, cout=1 both edges.
- Carry-in: from reset, a=0, b=0, cin=1 for 3 edges -> out=1, 2, 3. Then a=1, b=1, cin=1 -> out=5.
- Mid-stream reset: accumulate to a nonzero value, assert rst for one edge with a=200, b=200 -> out=0, cout=0. Next edge with a=3, b=4 -> out=12.
- Randomized check: 1000 random a/b/cin over the full range, compared against a 17-bit reference model each cycle. Include corners a=0, b=255, a=255, b=1, and an accumulator at 65535 with cin=1.
